// File: rtl/div15x8_pkg.sv
// Shared ZOOM divider constants, FSM state encoding and the quotient range helper.
// The widths match the mul7x8 multiply path this divider inverts.
package div15x8_pkg;

  localparam int NW   = 15;
  localparam int DW   = 8;
  localparam int QLIM = 127;
  localparam int CW   = $clog2(NW);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // True when a quotient cannot be fed back into the 7-bit multiplier operand.
  function automatic logic q_over_lim(input logic [NW-1:0] qv);
    return qv > NW'(QLIM);
  endfunction

endpackage

// File: rtl/div15x8.sv
// Sequential radix-2 restoring divider for the ZOOM scaler: q = n / d, r = n % d.
// One quotient bit per clock, valid/ready handshake on both sides.
//
// state  | meaning
// S_IDLE | in_ready high, waiting for operands
// S_CALC | one restoring iteration per clock, cnt counts down to 0
// S_DONE | out_valid high, result held until out_ready
module div15x8
  import div15x8_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [NW-1:0] n,
  input  logic [DW-1:0] d,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [NW-1:0] q,
  output logic [DW-1:0] r,
  output logic          q_ovf,
  output logic          div_zero
);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [NW-1:0] nq_sh;
  logic [DW-1:0] pr;
  logic [DW-1:0] d_reg;

  logic [DW:0]   pr_shift;
  logic [DW-1:0] pr_diff;
  logic          q_bit;
  logic [DW-1:0] pr_next;
  logic [NW-1:0] q_next;

  // The shifted remainder needs DW+1 bits for a full-range compare; after the
  // restore step it is always below d, so DW bits suffice to hold it.
  always_comb begin
    pr_shift = {pr, nq_sh[NW-1]};
    q_bit    = pr_shift >= {1'b0, d_reg};
    pr_diff  = DW'(pr_shift - {1'b0, d_reg});
    pr_next  = q_bit ? pr_diff : pr_shift[DW-1:0];
    q_next   = {nq_sh[NW-2:0], q_bit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      nq_sh     <= '0;
      pr        <= '0;
      d_reg     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      q         <= '0;
      r         <= '0;
      q_ovf     <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            nq_sh    <= n;
            d_reg    <= d;
            pr       <= '0;
            in_ready <= 1'b0;
            if (d == '0) begin
              q         <= '1;
              r         <= n[DW-1:0];
              q_ovf     <= 1'b1;
              div_zero  <= 1'b1;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end else begin
              cnt   <= CW'(NW - 1);
              state <= S_CALC;
            end
          end
        end

        S_CALC: begin
          pr    <= pr_next;
          nq_sh <= q_next;
          if (cnt == '0) begin
            q         <= q_next;
            r         <= pr_next;
            q_ovf     <= q_over_lim(q_next);
            div_zero  <= 1'b0;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
